// File: rtl/bcd_display_pkg.sv
// Shared constants for the BCD display controller: FSM encoding, datapath widths,
// the blank segment pattern and the double-dabble nibble adjust.
package bcd_display_pkg;

    localparam int NUM_W     = 10;
    localparam int SHIFT_CNT = 10;
    localparam int BCD_W     = 12;
    localparam int CNT_W     = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Segments are active-low, so all ones turns every segment off.
    localparam logic [6:0] SS_BLANK = 7'h7F;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_segment.sv
// Single-digit BCD to active-low seven-segment decoder, bit order {g,f,e,d,c,b,a}.
// Codes above 9 turn every segment off.
module seven_segment
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SS_BLANK;
        case (digit)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SS_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD (double-dabble, one bit per cycle) driving three seven-segment digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module bcd_display_ctrl
    import bcd_display_pkg::*;
#(
    parameter int SAT_VAL = 999
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic [6:0]       ss1_o,
    output logic [6:0]       ss2_o,
    output logic [6:0]       ss3_o
);

    logic [1:0]             state;
    logic [NUM_W-1:0]       bin_sr;
    logic [BCD_W-1:0]       bcd_work;
    logic [BCD_W-1:0]       disp;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+NUM_W-1:0] shifted;
    logic [6:0]             dec_units;
    logic [6:0]             dec_tens;
    logic [6:0]             dec_hund;

    function automatic logic [NUM_W-1:0] saturate(input logic [NUM_W-1:0] n);
        return (n > NUM_W'(SAT_VAL)) ? NUM_W'(SAT_VAL) : n;
    endfunction

    always_comb begin
        bcd_adj = dabble_adjust(bcd_work);
        shifted = {bcd_adj, bin_sr} << 1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_work <= '0;
            disp     <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        bin_sr   <= saturate(num_i);
                        bcd_work <= '0;
                        cnt      <= '0;
                        ovf      <= (num_i > 10'd999);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_work <= shifted[BCD_W+NUM_W-1:NUM_W];
                    bin_sr   <= shifted[NUM_W-1:0];
                    cnt      <= cnt + 1'b1;
                    // Display only takes the finished result, never a partial one.
                    if (cnt == CNT_W'(SHIFT_CNT - 1)) begin
                        disp  <= shifted[BCD_W+NUM_W-1:NUM_W];
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = (state == IDLE);
    assign done_o  = (state == DONE);
    assign ovf_o   = ovf;

    seven_segment u_ss_units (.digit(disp[3:0]),  .seg(dec_units));
    seven_segment u_ss_tens  (.digit(disp[7:4]),  .seg(dec_tens));
    seven_segment u_ss_hund  (.digit(disp[11:8]), .seg(dec_hund));

    always_comb begin
        ss1_o = dec_units;
        ss2_o = dec_tens;
        ss3_o = dec_hund;
`ifdef LEADING_ZERO_BLANK_EN
        if (disp[11:8] == 4'd0) begin
            ss3_o = SS_BLANK;
            if (disp[7:4] == 4'd0)
                ss2_o = SS_BLANK;
        end
`endif
    end

endmodule

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 SHALL have parameter SAT_VAL, default 999, the saturation value applied to inputs above 999.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port num_i, input, 10, the binary value to display, sampled only at handshake.
REQ-005 SHALL have port valid_i, input, 1, request to convert num_i.
REQ-006 SHALL have port ready_o, output, 1, high when a request can be accepted.
REQ-007 SHALL have port done_o, output, 1, one-cycle pulse when the display is updated.
REQ-008 SHALL have port ovf_o, output, 1, the last accepted num_i exceeded 999.
REQ-009 SHALL have ports ss1_o, ss2_o, ss3_o, output, 7 each, segment patterns for units, tens and hundreds.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-011 SHALL assert ready_o only in IDLE; handshake = valid_i && ready_o at a rising edge.
REQ-012 SHALL, on handshake, load min(num_i, SAT_VAL) into a 10-bit shift register, clear the 12-bit BCD work register, clear the 4-bit shift counter, set ovf_o = (num_i > 999), and enter SHIFT.
REQ-013 SHALL, each SHIFT cycle, apply double-dabble: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one, and increment the counter.
REQ-014 SHALL, on the 10th shift edge (counter == 9), write the shifted BCD result into both the work register and the display register, and enter DONE.
REQ-015 SHALL hold done_o high for exactly the one DONE cycle, then return to IDLE on the next edge.
REQ-016 SHALL produce a fixed latency: handshake at edge E0; display updated at E10; done_o high between E10 and E11; ready_o high again after E11. Throughput is one conversion per 12 cycles.
REQ-017 SHALL ignore valid_i and num_i in SHIFT and DONE; requests are neither queued nor dropped silently, because ready_o is low.
REQ-018 SHALL hold ss1_o..ss3_o steady (previous value) throughout SHIFT, with no intermediate values shown.
REQ-019 SHALL derive ss outputs combinationally from the display register via the seven_segment decoder.
REQ-020 SHALL convert 999 to digits 9/9/9 with ovf_o=0, and 1000..1023 to 9/9/9 with ovf_o=1.

Reset
REQ-021 SHALL, on rst_i, set state IDLE, display register to 000, work registers to 0, counter to 0, ovf_o=0, and done_o=0.
REQ-022 SHALL, when rst_i is high mid-SHIFT or in DONE, abort the conversion with no done_o and set the display to 000; ready_o is high the cycle after reset deasserts.
REQ-023 SHALL give rst_i priority over a simultaneous handshake.

Configuration
REQ-024 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-025 With LEADING_ZERO_BLANK_EN defined, SHALL drive ss3_o = SS_BLANK when hundreds == 0, and ss2_o = SS_BLANK when hundreds == 0 and tens == 0; ss1_o is always decoded.
REQ-026 Without LEADING_ZERO_BLANK_EN, SHALL always decode all three digits, including leading zeros.

Structure
REQ-027 SHALL place in package bcd_display_pkg: state encoding (IDLE/SHIFT/DONE), NUM_W=10, SHIFT_CNT=10, BCD_W=12, SS_BLANK=7'h7F (all segments off, active-low).
REQ-028 SHALL instantiate the existing seven_segment sub-module three times; no other sub-modules.

Verification
REQ-029 Reset, then num_i=0 with valid_i -> done_o at cycle 11 after handshake; digits 0/0/0; ovf_o=0; ready_o high at cycle 12.
REQ-030 num_i=987 -> units 7, tens 8, hundreds 9; ovf_o=0; display unchanged before done_o.
REQ-031 num_i=1023 -> display 9/9/9, ovf_o=1; then num_i=5 -> 0/0/5, ovf_o=0.
REQ-032 Accept 123, hold valid_i with num_i=456 during SHIFT -> ready_o low, 456 not accepted before done_o, display shows 123 after done_o.
REQ-033 Accept 456, assert rst_i at shift 5 -> no done_o, display 000, ready_o high the cycle after rst_i falls.
REQ-034 LEADING_ZERO_BLANK_EN defined: 7 -> ss3_o=ss2_o=SS_BLANK, ss1_o shows 7; 40 -> ss3_o=SS_BLANK, tens 4, units 0; 0 -> units 0 shown.
